// File: rtl/mem_req_issue.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_issue
// Brief    : Request-issue stage in front of the unified memory block.
//            Buffers tagged load/store requests in a FIFO, issues one at a
//            time to memory as a single-cycle enable pulse, waits for the
//            ack with the matching tag and returns a one-cycle response.
// Options  : MEM_REQ_TIMEOUT_EN - adds an ack watchdog of TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_issue #(
    parameter int DEPTH   = 4,
    parameter int EN_W    = 4,
    parameter int ADDR_W  = 2048,
    parameter int DATA_W  = 8192,
    parameter int TAG_W   = 7,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_gm_or_lds,
    input  logic [EN_W-1:0]   req_rd_en,
    input  logic [EN_W-1:0]   req_wr_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wr_data,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_gm_or_lds,
    output logic [EN_W-1:0]   mem_rd_en,
    output logic [EN_W-1:0]   mem_wr_en,
    output logic [ADDR_W-1:0] mem_addresses,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [TAG_W-1:0]  mem_input_tag,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [TAG_W-1:0]  mem_output_tag,
    input  logic              mem_ack,
    output logic              busy,
    output logic [2:0]        err
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam int               CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // FIFO payload storage
    logic              fifo_gm_q   [DEPTH];
    logic [EN_W-1:0]   fifo_rd_q   [DEPTH];
    logic [EN_W-1:0]   fifo_wr_q   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [TAG_W-1:0]  fifo_tag_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Issue engine state
    logic [1:0]        state_q, state_d;
    logic [2:0]        err_q, err_d;
    logic              resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              gm_q, gm_d;
    logic [EN_W-1:0]   rd_en_q, rd_en_d;
    logic [EN_W-1:0]   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TAG_W-1:0]  itag_q, itag_d;

    logic w_push;
    logic w_pop;
    logic w_head_zero;
    logic w_timeout;

    assign req_ready   = (count_q != C_FULL);
    assign w_push      = req_valid && req_ready;
    // Pop only from a non-empty FIFO while idle; a same-edge push is never bypassed.
    assign w_pop       = (state_q == S_IDLE) && (count_q != '0);
    assign w_head_zero = (fifo_rd_q[rd_ptr_q] == '0) && (fifo_wr_q[rd_ptr_q] == '0);

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int               TMR_W      = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] timer_q;

    assign w_timeout = (timer_q == C_TMR_LAST);

    // Watchdog counts WAIT cycles and restarts from zero on every entry to WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q <= '0;
        end else if (state_q != S_WAIT) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    // Payload write; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_gm_q[wr_ptr_q]   <= req_gm_or_lds;
            fifo_rd_q[wr_ptr_q]   <= req_rd_en;
            fifo_wr_q[wr_ptr_q]   <= req_wr_en;
            fifo_addr_q[wr_ptr_q] <= req_addr;
            fifo_data_q[wr_ptr_q] <= req_wr_data;
            fifo_tag_q[wr_ptr_q]  <= req_tag;
        end
    end

    // Wrapping pointers plus an explicit occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT engine and its outputs.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        gm_d         = gm_q;
        rd_en_d      = '0;
        wr_en_d      = '0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        itag_d       = itag_q;
        case (state_q)
            S_IDLE: begin
                if (mem_ack) err_d[1] = 1'b1;
                if (w_pop) begin
                    if (w_head_zero) begin
                        // Nothing to send to memory: answer directly with zero data.
                        resp_valid_d = 1'b1;
                        resp_tag_d   = fifo_tag_q[rd_ptr_q];
                        resp_data_d  = '0;
                    end else begin
                        gm_d    = fifo_gm_q[rd_ptr_q];
                        rd_en_d = fifo_rd_q[rd_ptr_q];
                        wr_en_d = fifo_wr_q[rd_ptr_q];
                        addr_d  = fifo_addr_q[rd_ptr_q];
                        wdata_d = fifo_data_q[rd_ptr_q];
                        itag_d  = fifo_tag_q[rd_ptr_q];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_ack) err_d[1] = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack && (mem_output_tag == itag_q)) begin
                    resp_valid_d = 1'b1;
                    resp_tag_d   = itag_q;
                    resp_data_d  = mem_rd_data;
                    state_d      = S_IDLE;
                end else begin
                    if (mem_ack) err_d[0] = 1'b1;
                    if (w_timeout) begin
                        err_d[2]     = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_tag_d   = itag_q;
                        resp_data_d  = '0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Engine registers; reset discards any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            err_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            gm_q         <= 1'b0;
            rd_en_q      <= '0;
            wr_en_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            itag_q       <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
            gm_q         <= gm_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            itag_q       <= itag_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_tag      = resp_tag_q;
    assign resp_data     = resp_data_q;
    assign mem_gm_or_lds = gm_q;
    assign mem_rd_en     = rd_en_q;
    assign mem_wr_en     = wr_en_q;
    assign mem_addresses = addr_q;
    assign mem_wr_data   = wdata_q;
    assign mem_input_tag = itag_q;
    assign err           = err_q;
    assign busy          = (count_q != '0) || (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_req_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_issue
// Brief    : Self-checking bench for mem_req_issue: directed scenarios plus a
//            randomized run against an in-order request/response model.
// Options  : MEM_REQ_TIMEOUT_EN - selects the expected watchdog behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_issue;

    localparam int DEPTH   = 4;
    localparam int EN_W    = 4;
    localparam int ADDR_W  = 2048;
    localparam int DATA_W  = 8192;
    localparam int TAG_W   = 7;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic              gm;
        logic [EN_W-1:0]   rd;
        logic [EN_W-1:0]   wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_gm_or_lds;
    logic [EN_W-1:0]   req_rd_en;
    logic [EN_W-1:0]   req_wr_en;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wr_data;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic [TAG_W-1:0]  resp_tag;
    logic [DATA_W-1:0] resp_data;
    logic              mem_gm_or_lds;
    logic [EN_W-1:0]   mem_rd_en;
    logic [EN_W-1:0]   mem_wr_en;
    logic [ADDR_W-1:0] mem_addresses;
    logic [DATA_W-1:0] mem_wr_data;
    logic [TAG_W-1:0]  mem_input_tag;
    logic [DATA_W-1:0] mem_rd_data;
    logic [TAG_W-1:0]  mem_output_tag;
    logic              mem_ack;
    logic              busy;
    logic [2:0]        err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_req_issue #(
        .DEPTH(DEPTH), .EN_W(EN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_gm_or_lds(req_gm_or_lds),
        .req_rd_en(req_rd_en), .req_wr_en(req_wr_en), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
        .mem_gm_or_lds(mem_gm_or_lds), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addresses(mem_addresses), .mem_wr_data(mem_wr_data),
        .mem_input_tag(mem_input_tag), .mem_rd_data(mem_rd_data),
        .mem_output_tag(mem_output_tag), .mem_ack(mem_ack),
        .busy(busy), .err(err)
    );

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] v;
        for (int i = 0; i < ADDR_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Present one request and hold it until accepted; returns at the negedge after acceptance.
    task automatic push_one(input logic [TAG_W-1:0] tag, input logic gm, input logic [EN_W-1:0] rd,
                            input logic [EN_W-1:0] wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data, output bit ok);
        req_tag = tag; req_gm_or_lds = gm; req_rd_en = rd; req_wr_en = wr;
        req_addr = addr; req_wr_data = data; req_valid = 1'b1;
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        ok = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for a memory enable pulse.
    task automatic wait_pulse(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((mem_rd_en | mem_wr_en) != '0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = 1'b0; req_gm_or_lds = 1'b0; req_rd_en = '0; req_wr_en = '0;
        req_addr = '0; req_wr_data = '0; req_tag = '0;
        mem_rd_data = '0; mem_output_tag = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_vec++; if ({resp_valid, resp_tag, busy, err} !== '0) begin n_err++;
            $display("FAIL reset_resp: got valid=%b tag=%h busy=%b err=%b want all 0", resp_valid, resp_tag, busy, err); end
        n_vec++; if ({mem_gm_or_lds, mem_rd_en, mem_wr_en, mem_input_tag} !== '0) begin n_err++;
            $display("FAIL reset_mem_ctl: got gm=%b rd=%b wr=%b tag=%h want 0", mem_gm_or_lds, mem_rd_en, mem_wr_en, mem_input_tag); end
        n_vec++; if (mem_addresses !== '0 || mem_wr_data !== '0 || resp_data !== '0) begin n_err++;
            $display("FAIL reset_buses: got addr=%h wdata=%h rdata=%h want 0", mem_addresses[63:0], mem_wr_data[63:0], resp_data[63:0]); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit ok;
        addr = rand_addr();
        addr[127:0] = 128'h00000034_00000024_00000014_00000004;
        data = rand_data();
        push_one(7'd1, 1'b1, 4'b0000, 4'b0101, addr, data, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL store_accept: got %b want 1", ok); end
        @(negedge clk);
        n_vec++; if ({mem_wr_en, mem_rd_en, mem_gm_or_lds, mem_input_tag} !== {4'b0101, 4'b0000, 1'b1, 7'd1}) begin n_err++;
            $display("FAIL store_pulse: got wr=%b rd=%b gm=%b tag=%h want wr=0101 rd=0000 gm=1 tag=01",
                     mem_wr_en, mem_rd_en, mem_gm_or_lds, mem_input_tag); end
        n_vec++; if (mem_addresses !== addr || mem_wr_data !== data) begin n_err++;
            $display("FAIL store_payload: got addr=%h data=%h want addr=%h data=%h",
                     mem_addresses[127:0], mem_wr_data[63:0], addr[127:0], data[63:0]); end
        @(negedge clk);
        n_vec++; if (mem_wr_en !== 4'b0000 || mem_addresses !== addr || mem_input_tag !== 7'd1) begin n_err++;
            $display("FAIL store_one_cycle: got wr=%b tag=%h addr=%h want wr=0000 tag=01 held addr", mem_wr_en, mem_input_tag, mem_addresses[63:0]); end
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL store_early_resp: got %b want 0", resp_valid); end
        mem_ack = 1'b1; mem_output_tag = 7'd1; mem_rd_data = rand_data();
        @(negedge clk);
        mem_ack = 1'b0;
        n_vec++; if ({resp_valid, resp_tag, err} !== {1'b1, 7'd1, 3'b000}) begin n_err++;
            $display("FAIL store_resp: got valid=%b tag=%h err=%b want 1 01 000", resp_valid, resp_tag, err); end
        @(negedge clk);
        n_vec++; if ({resp_valid, busy} !== 2'b00) begin n_err++;
            $display("FAIL store_resp_pulse: got valid=%b busy=%b want 0 0", resp_valid, busy); end
    endtask

    task automatic test_load;
        logic [DATA_W-1:0] rdata;
        bit ok, seen;
        rdata = rand_data();
        rdata[127:0] = 128'h00000001_00000002_00000003_00000004;
        push_one(7'd2, 1'b0, 4'b0101, 4'b0000, rand_addr(), rand_data(), ok);
        wait_pulse(seen);
        n_vec++; if ({seen, mem_rd_en, mem_wr_en, mem_input_tag} !== {1'b1, 4'b0101, 4'b0000, 7'd2}) begin n_err++;
            $display("FAIL load_pulse: got seen=%b rd=%b wr=%b tag=%h want 1 0101 0000 02", seen, mem_rd_en, mem_wr_en, mem_input_tag); end
        @(negedge clk);
        mem_ack = 1'b1; mem_output_tag = 7'd2; mem_rd_data = rdata;
        @(negedge clk);
        mem_ack = 1'b0;
        n_vec++; if ({resp_valid, resp_tag} !== {1'b1, 7'd2} || resp_data !== rdata) begin n_err++;
            $display("FAIL load_resp: got valid=%b tag=%h data=%h want 1 02 %h", resp_valid, resp_tag, resp_data[127:0], rdata[127:0]); end
        @(negedge clk);
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL load_resp_pulse: got %b want 0", resp_valid); end
    endtask

    task automatic test_full_order;
        logic [TAG_W-1:0] exp_tags[$];
        bit ok, seen;
        exp_tags.push_back(7'd10);
        for (int t = 3; t <= 7; t++) exp_tags.push_back(TAG_W'(t));
        push_one(7'd10, 1'b0, 4'b0001, 4'b0000, rand_addr(), rand_data(), ok);
        wait_pulse(seen);
        n_vec++; if ({seen, mem_input_tag} !== {1'b1, 7'd10}) begin n_err++;
            $display("FAIL full_blocker: got seen=%b tag=%h want 1 0a", seen, mem_input_tag); end
        for (int t = 3; t <= 6; t++) begin
            n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_%0d: got %b want 1", t, req_ready); end
            req_valid = 1'b1; req_tag = TAG_W'(t); req_rd_en = 4'b0001; req_wr_en = 4'b0000;
            req_addr = rand_addr(); req_wr_data = rand_data();
            @(negedge clk);
        end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL full_after4: got ready=%b want 0", req_ready); end
        req_tag = 7'd7;
        repeat (3) @(negedge clk);
        n_vec++; if ({req_ready, busy} !== 2'b01) begin n_err++;
            $display("FAIL full_stall: got ready=%b busy=%b want 0 1", req_ready, busy); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                wait_pulse(seen);
                n_vec++; if ({seen, mem_input_tag} !== {1'b1, exp_tags[i]}) begin n_err++;
                    $display("FAIL order_issue_%0d: got seen=%b tag=%h want 1 %h", i, seen, mem_input_tag, exp_tags[i]); end
            end
            if (i == 1) begin
                n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_space_frees: got %b want 1", req_ready); end
            end
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            mem_ack = 1'b1; mem_output_tag = exp_tags[i]; mem_rd_data = rand_data();
            @(negedge clk);
            mem_ack = 1'b0;
            n_vec++; if ({resp_valid, resp_tag} !== {1'b1, exp_tags[i]}) begin n_err++;
                $display("FAIL order_resp_%0d: got valid=%b tag=%h want 1 %h", i, resp_valid, resp_tag, exp_tags[i]); end
        end
        @(negedge clk);
        n_vec++; if ({busy, err} !== 4'b0000) begin n_err++; $display("FAIL full_drained: got busy=%b err=%b want 0 000", busy, err); end
    endtask

    task automatic test_random;
        req_t model_q[$];
        req_t cur, exp;
        logic [DATA_W-1:0] ack_data, want;
        logic [TAG_W-1:0]  issued_tag;
        int  to_send = 40, done = 0, cyc = 0, ack_wait = 0;
        bit  acc_pending = 1'b0, issued = 1'b0;
        ack_data = '0; issued_tag = '0;
        while (done < 40 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (acc_pending) begin
                model_q.push_back(cur);
                req_valid = 1'b0;
                acc_pending = 1'b0;
            end
            if (mem_ack) mem_ack = 1'b0;
            if (ack_wait > 0) begin
                ack_wait--;
                if (ack_wait == 0) begin
                    mem_ack = 1'b1; mem_output_tag = issued_tag; mem_rd_data = ack_data;
                end
            end
            if ((mem_rd_en | mem_wr_en) != '0) begin
                n_vec++;
                if (issued || model_q.size() == 0) begin
                    n_err++; $display("FAIL rand_issue: got unexpected pulse tag=%h want none", mem_input_tag);
                end else begin
                    exp = model_q[0];
                    if ({mem_input_tag, mem_gm_or_lds, mem_rd_en, mem_wr_en} !== {exp.tag, exp.gm, exp.rd, exp.wr} ||
                        mem_addresses !== exp.addr || mem_wr_data !== exp.data) begin
                        n_err++; $display("FAIL rand_issue: got tag=%h gm=%b rd=%b wr=%b want tag=%h gm=%b rd=%b wr=%b",
                                          mem_input_tag, mem_gm_or_lds, mem_rd_en, mem_wr_en, exp.tag, exp.gm, exp.rd, exp.wr);
                    end
                    issued = 1'b1; issued_tag = exp.tag; ack_data = rand_data();
                    ack_wait = 1 + int'($urandom_range(0, 3));
                end
            end
            if (resp_valid) begin
                n_vec++;
                if (model_q.size() == 0) begin
                    n_err++; $display("FAIL rand_resp: got unexpected resp tag=%h want none", resp_tag);
                end else begin
                    exp  = model_q.pop_front();
                    want = issued ? ack_data : '0;
                    if (resp_tag !== exp.tag || resp_data !== want || (!issued && (exp.rd | exp.wr) != '0)) begin
                        n_err++; $display("FAIL rand_resp: got tag=%h data=%h issued=%b want tag=%h data=%h",
                                          resp_tag, resp_data[63:0], issued, exp.tag, want[63:0]);
                    end
                    issued = 1'b0;
                    done++;
                end
            end
            if (!req_valid && to_send > 0 && $urandom_range(0, 2) != 0) begin
                cur.tag = TAG_W'($urandom);
                cur.gm  = 1'($urandom);
                if ($urandom_range(0, 4) == 0) begin
                    cur.rd = '0; cur.wr = '0;
                end else begin
                    cur.rd = EN_W'($urandom); cur.wr = EN_W'($urandom);
                end
                cur.addr = rand_addr(); cur.data = rand_data();
                req_tag = cur.tag; req_gm_or_lds = cur.gm; req_rd_en = cur.rd; req_wr_en = cur.wr;
                req_addr = cur.addr; req_wr_data = cur.data; req_valid = 1'b1;
                to_send--;
            end
            if (req_valid && req_ready) acc_pending = 1'b1;
        end
        mem_ack = 1'b0;
        n_vec++; if (done !== 40) begin n_err++; $display("FAIL rand_complete: got %0d responses want 40", done); end
        n_vec++; if (err !== 3'b000) begin n_err++; $display("FAIL rand_err: got %b want 000", err); end
    endtask

    task automatic test_mismatch_stray;
        bit ok, seen;
        push_one(7'd8, 1'b0, 4'b0011, 4'b0000, rand_addr(), rand_data(), ok);
        wait_pulse(seen);
        n_vec++; if ({seen, mem_input_tag} !== {1'b1, 7'd8}) begin n_err++;
            $display("FAIL mismatch_issue: got seen=%b tag=%h want 1 08", seen, mem_input_tag); end
        @(negedge clk);
        mem_ack = 1'b1; mem_output_tag = 7'd9; mem_rd_data = rand_data();
        @(negedge clk);
        mem_ack = 1'b0;
        n_vec++; if ({err, resp_valid, busy} !== {3'b001, 1'b0, 1'b1}) begin n_err++;
            $display("FAIL mismatch_flag: got err=%b valid=%b busy=%b want 001 0 1", err, resp_valid, busy); end
        repeat (2) @(negedge clk);
        n_vec++; if ({resp_valid, busy} !== 2'b01) begin n_err++;
            $display("FAIL mismatch_still_wait: got valid=%b busy=%b want 0 1", resp_valid, busy); end
        mem_ack = 1'b1; mem_output_tag = 7'd8;
        @(negedge clk);
        mem_ack = 1'b0;
        n_vec++; if ({resp_valid, resp_tag} !== {1'b1, 7'd8}) begin n_err++;
            $display("FAIL mismatch_late_match: got valid=%b tag=%h want 1 08", resp_valid, resp_tag); end
        @(negedge clk);
        mem_ack = 1'b1; mem_output_tag = 7'd8;
        @(negedge clk);
        mem_ack = 1'b0;
        n_vec++; if ({err, resp_valid} !== {3'b011, 1'b0}) begin n_err++;
            $display("FAIL stray_ack: got err=%b valid=%b want 011 0", err, resp_valid); end
    endtask

    task automatic test_reset_mid_wait;
        bit ok, seen;
        push_one(7'd11, 1'b1, 4'b1000, 4'b0001, rand_addr(), rand_data(), ok);
        wait_pulse(seen);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++; if ({mem_gm_or_lds, mem_rd_en, mem_wr_en, mem_input_tag, resp_valid, busy, err} !== '0) begin n_err++;
            $display("FAIL rstwait_outputs: got gm=%b rd=%b wr=%b tag=%h valid=%b busy=%b err=%b want 0",
                     mem_gm_or_lds, mem_rd_en, mem_wr_en, mem_input_tag, resp_valid, busy, err); end
        n_vec++; if (req_ready !== 1'b1 || mem_addresses !== '0 || mem_wr_data !== '0) begin n_err++;
            $display("FAIL rstwait_buses: got ready=%b addr=%h data=%h want 1 0 0", req_ready, mem_addresses[63:0], mem_wr_data[63:0]); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_output_tag = 7'd11;
        @(negedge clk);
        mem_ack = 1'b0;
        n_vec++; if ({resp_valid, err} !== {1'b0, 3'b010}) begin n_err++;
            $display("FAIL rstwait_late_ack: got valid=%b err=%b want 0 010", resp_valid, err); end
        @(negedge clk);
        n_vec++; if ({resp_valid, busy} !== 2'b00) begin n_err++;
            $display("FAIL rstwait_idle: got valid=%b busy=%b want 0 0", resp_valid, busy); end
    endtask

    task automatic test_timeout;
        bit ok, seen;
        int first = -1;
        logic [TAG_W-1:0]  tag_at = '0;
        logic [DATA_W-1:0] data_at = '0;
        push_one(7'd12, 1'b0, 4'b0010, 4'b0000, rand_addr(), rand_data(), ok);
        wait_pulse(seen);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (resp_valid && first < 0) begin
                first = k; tag_at = resp_tag; data_at = resp_data;
            end
        end
`ifdef MEM_REQ_TIMEOUT_EN
        n_vec++; if (first !== TIMEOUT + 1) begin n_err++;
            $display("FAIL timeout_latency: got resp at +%0d want +%0d", first, TIMEOUT + 1); end
        n_vec++; if (tag_at !== 7'd12 || data_at !== '0 || err[2] !== 1'b1) begin n_err++;
            $display("FAIL timeout_resp: got tag=%h data=%h err=%b want 0c 0 1xx", tag_at, data_at[63:0], err); end
`else
        n_vec++; if (first !== -1) begin n_err++; $display("FAIL no_timeout_resp: got resp at +%0d want none", first); end
        n_vec++; if ({err[2], busy} !== 2'b01) begin n_err++;
            $display("FAIL no_timeout_state: got err2=%b busy=%b want 0 1", err[2], busy); end
`endif
    endtask

    initial begin
        test_reset;
        test_store;
        test_load;
        test_full_order;
        test_random;
        test_mismatch_stray;
        test_reset_mid_wait;
        test_timeout;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
